mux_rr_scheduler: RTL and testbench



---
 rtl/mux_rr_scheduler.sv | 105 ++++++++++
 tb/tb_mux_rr_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin scheduler driving a shared N:1 bit mux with bounded bursts

module mux_rr_scheduler #(
    parameter int M        = 4,
    parameter int N        = 2**M,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] in,
    output logic [N-1:0] grant,
    output logic [M-1:0] sel,
    output logic         y,
    output logic         valid
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [M-1:0]  ptr, ptr_nx, sel_nx;
    logic [N-1:0]  grant_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          do_arb;
    logic [M:0]    win;

    // Rotate req so the priority pointer lands on bit 0, then take the lowest set bit.
    // Result MSB flags "found"; low bits are the absolute winner index (wraps mod N).
    function automatic logic [M:0] pick(input logic [N-1:0] r, input logic [M-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [M:0]     res;
        dbl = {r, r} >> p;
        rot = dbl[N-1:0];
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                res = {1'b1, M'(i) + p};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        grant_nx = grant;
        sel_nx   = sel;
        hold_nx  = hold_cnt;
        do_arb   = 1'b0;
        case (state)
            IDLE: do_arb = 1'b1;
            BUSY: begin
                if (!req[sel] || hold_cnt == HOLD_LAST) begin
                    ptr_nx = sel + 1'b1;
                    do_arb = 1'b1;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Re-arbitration on release uses the advanced pointer in the same edge.
        win = pick(req, ptr_nx);
        if (do_arb) begin
            if (win[M]) begin
                state_nx = BUSY;
                grant_nx = N'(1) << win[M-1:0];
                sel_nx   = win[M-1:0];
                hold_nx  = '0;
            end else begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
            y        <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            grant    <= grant_nx;
            sel      <= sel_nx;
            if (state == BUSY) begin
                y     <= in[sel];
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - scoreboard bench for mux_rr_scheduler at MAX_HOLD 4 and 1

module tb_mux_rr_scheduler;

    localparam int M = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] in;

    logic [N-1:0] grant0, grant1;
    logic [M-1:0] sel0, sel1;
    logic         y0, y1, valid0, valid1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit           busy;
        int           ptr;
        int           hold;
        logic [N-1:0] grant;
        logic [M-1:0] sel;
        logic         y;
        logic         valid;
    } ms_t;

    ms_t m0, m1;
    ms_t q0[$];
    ms_t q1[$];

    always #5 clk = ~clk;

    mux_rr_scheduler #(.M(M), .N(N), .MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .in(in),
        .grant(grant0), .sel(sel0), .y(y0), .valid(valid0)
    );

    mux_rr_scheduler #(.M(M), .N(N), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .in(in),
        .grant(grant1), .sel(sel1), .y(y1), .valid(valid1)
    );

    function automatic ms_t reset_state();
        ms_t s;
        s.busy = 1'b0; s.ptr = 0; s.hold = 0;
        s.grant = '0; s.sel = '0; s.y = 1'b0; s.valid = 1'b0;
        return s;
    endfunction

    // First requester at or after p, going round the ring; -1 if none.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic ms_t step(input ms_t s, input logic [N-1:0] r, input logic [N-1:0] d, input int mh);
        ms_t n;
        int  w;
        bit  arb;
        n = s;
        arb = 1'b0;
        if (s.busy) begin
            n.valid = 1'b1;
            n.y = d[s.sel];
            if (!r[s.sel] || s.hold == mh - 1) begin
                n.ptr = (int'(s.sel) + 1) % N;
                arb = 1'b1;
            end else begin
                n.hold = s.hold + 1;
            end
        end else begin
            n.valid = 1'b0;
            arb = 1'b1;
        end
        if (arb) begin
            w = pick(r, n.ptr);
            if (w < 0) begin
                n.busy = 1'b0;
                n.grant = '0;
            end else begin
                n.busy = 1'b1;
                n.grant = '0;
                n.grant[w] = 1'b1;
                n.sel = M'(w);
                n.hold = 0;
            end
        end
        return n;
    endfunction

    task automatic compare(input string name, input ms_t e, input logic [N-1:0] g,
                           input logic [M-1:0] s, input logic yy, input logic v);
        checks++;
        if (g !== e.grant || s !== e.sel || v !== e.valid || yy !== e.y) begin
            errors++;
            $display("FAIL %s t=%0t got grant=%h sel=%0d valid=%b y=%b expected grant=%h sel=%0d valid=%b y=%b",
                     name, $time, g, s, v, yy, e.grant, e.sel, e.valid, e.y);
        end
    endtask

    // Monitor: one expected record per clock edge for each instance.
    initial begin
        ms_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q0.size() == 0 || q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got q0=%0d q1=%0d expected >=1", $time, q0.size(), q1.size());
                end else begin
                    e = q0.pop_front();
                    compare("hold4", e, grant0, sel0, y0, valid0);
                    e = q1.pop_front();
                    compare("hold1", e, grant1, sel1, y1, valid1);
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d);
        @(negedge clk);
        rst = 1'b0;
        req = r;
        in  = d;
        m0 = step(m0, r, d, 4);
        m1 = step(m1, r, d, 1);
        q0.push_back(m0);
        q1.push_back(m1);
        mon_en = 1'b1;
    endtask

    task automatic async_reset(input string name);
        ms_t z;
        z = reset_state();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare({name, "_h4"}, z, grant0, sel0, y0, valid0);
        compare({name, "_h1"}, z, grant1, sel1, y1, valid1);
        m0 = z;
        m1 = z;
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    initial begin
        logic [N-1:0] r, d;
        rst = 1'b1;
        req = '0;
        in  = '0;
        m0 = reset_state();
        m1 = reset_state();
        #3;
        compare("por_h4", m0, grant0, sel0, y0, valid0);
        compare("por_h1", m1, grant1, sel1, y1, valid1);
        @(negedge clk);

        // Single requester with data high: repeated re-grant, no gap.
        repeat (12) cyc(16'h0004, 16'h0004);

        // Asynchronous reset mid-burst, then idle.
        async_reset("rst_mid");
        repeat (3) cyc(16'h0000, 16'hffff);

        // Two requesters at the ends of the ring: wrap 15 -> 0.
        repeat (20) cyc(16'h8001, 16'h8000);

        // Early release of idx0.
        async_reset("rst_pre4");
        cyc(16'h0003, 16'h0001);
        cyc(16'h0003, 16'h0001);
        repeat (6) cyc(16'h0002, 16'h0001);

        // Data select on idx9 while in[10] toggles the other way.
        for (int i = 0; i < 10; i++) cyc(16'h0200, (i % 2 == 0) ? 16'h0200 : 16'h0400);

        // Three-way rotation then all-zero request.
        repeat (10) cyc(16'h0007, 16'h0005);
        repeat (3) cyc(16'h0000, 16'h0005);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(63) == 0) begin
                async_reset("rst_rand");
            end else begin
                case ($urandom_range(3))
                    0: r = '0;
                    1: r = N'($urandom & $urandom & $urandom);
                    2: r = N'(1) << $urandom_range(N - 1);
                    default: r = N'($urandom);
                endcase
                d = N'($urandom);
                cyc(r, d);
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got q0=%0d q1=%0d expected 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
